// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the h2f reset sequencer: FSM state encoding,
// counter sizing, and the parameter limits the sequencer clamps against.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_RELEASE,
        ST_RUN,
        ST_QUIESCE,
        ST_HOLD
    } state_t;

    localparam int unsigned MAX_STAGES      = 8;
    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_CYCLES      = 1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Width of the shared down-counter: must hold the largest reload value.
    function automatic int unsigned cnt_width(input int unsigned stage_delay,
                                              input int unsigned hold_cycles,
                                              input int unsigned quiesce_timeout);
        return $clog2(max3(stage_delay, hold_cycles, quiesce_timeout) + 1);
    endfunction

    function automatic int unsigned at_least(input int unsigned v,
                                             input int unsigned lo);
        return (v < lo) ? lo : v;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously with arst_n, deasserts
// SYNC_STAGES clk edges after arst_n rises.
module rst_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    output logic sync_rst_n
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = chain[SYNC_STAGES-1];

endmodule

// File: rtl/h2f_reset_sequencer.sv
// Fabric-side HPS reset sequencer: async assert, synchronised staged release,
// quiesce handshake before soft resets. Optional macro: RST_SEQ_TIMEOUT_EN.
module h2f_reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned STAGE_DELAY     = 4,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned QUIESCE_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  h2f_rst_n,
    input  logic                  soft_req,
    input  logic                  quiesce_ack,
    output logic                  quiesce_req,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic                  timeout_flag
);

    localparam int unsigned SYNC_EFF = at_least(SYNC_STAGES, MIN_SYNC_STAGES);
    localparam int unsigned D_EFF    = at_least(STAGE_DELAY, MIN_CYCLES);
    localparam int unsigned H_EFF    = at_least(HOLD_CYCLES, MIN_CYCLES);
    localparam int unsigned T_EFF    = at_least(QUIESCE_TIMEOUT, MIN_CYCLES);
    localparam int unsigned CNT_W    = cnt_width(D_EFF, H_EFF, T_EFF);
    localparam int unsigned IDX_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] D_RELOAD = CNT_W'(D_EFF - 1);
    localparam logic [CNT_W-1:0] H_RELOAD = CNT_W'(H_EFF - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    logic arst_n;
    logic sync_rst_n;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic                    qreq_q, qreq_d;
    logic                    release_step;
    logic                    stage_fire;
    logic                    last_stage;
    logic                    q_timeout;
    logic                    q_exit;

    assign arst_n = rst_n & h2f_rst_n;

    rst_sync #(
        .SYNC_STAGES(SYNC_EFF)
    ) u_rst_sync (
        .clk       (clk),
        .arst_n    (arst_n),
        .sync_rst_n(sync_rst_n)
    );

    // The first RESET cycle with the synchroniser high already counts as a
    // release-delay cycle; cnt_q sits at D_RELOAD throughout RESET.
    assign release_step = ((state_q == ST_RESET) && sync_rst_n) || (state_q == ST_RELEASE);
    assign stage_fire   = release_step && (cnt_q == '0);
    assign last_stage   = (idx_q == LAST_IDX);

`ifdef RST_SEQ_TIMEOUT_EN
    assign q_timeout = !quiesce_ack && (cnt_q == '0);
`else
    assign q_timeout = 1'b0;
`endif
    assign q_exit = (state_q == ST_QUIESCE) && (quiesce_ack || q_timeout);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_RESET;
            cnt_q   <= D_RELOAD;
            idx_q   <= '0;
            rst_q   <= '0;
            ready_q <= 1'b0;
            qreq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            qreq_q  <= qreq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (release_step) begin
            if (stage_fire) begin
                cnt_d   = D_RELOAD;
                idx_d   = last_stage ? '0 : idx_q + 1'b1;
                state_d = last_stage ? ST_RUN : ST_RELEASE;
            end else begin
                cnt_d   = cnt_q - 1'b1;
                state_d = ST_RELEASE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (soft_req) begin
                        state_d = ST_QUIESCE;
`ifdef RST_SEQ_TIMEOUT_EN
                        cnt_d   = CNT_W'(T_EFF - 1);
`endif
                    end
                end
                ST_QUIESCE: begin
                    if (q_exit) begin
                        state_d = ST_HOLD;
                        cnt_d   = H_RELOAD;
`ifdef RST_SEQ_TIMEOUT_EN
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
`endif
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RELEASE;
                        cnt_d   = D_RELOAD;
                        idx_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rst_d   = rst_q;
        ready_d = ready_q;
        qreq_d  = qreq_q;
        if (stage_fire) begin
            rst_d[idx_q] = 1'b1;
            if (last_stage) ready_d = 1'b1;
        end
        if ((state_q == ST_RUN) && soft_req) begin
            ready_d = 1'b0;
            qreq_d  = 1'b1;
        end
        if (q_exit) begin
            qreq_d = 1'b0;
            rst_d  = '0;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    logic flag_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            flag_q <= 1'b0;
        end else if (q_exit && q_timeout) begin
            flag_q <= 1'b1;
        end
    end

    assign timeout_flag = flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign rst_out_n   = rst_q;
    assign ready       = ready_q;
    assign quiesce_req = qreq_q;

endmodule

// File: tb/tb_h2f_reset_sequencer.sv
// Directed self-checking bench for h2f_reset_sequencer (3 stages, sync 2,
// delay 4, hold 16, timeout 256). Timeout checks follow RST_SEQ_TIMEOUT_EN.
module tb_h2f_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       h2f_rst_n = 1'b1;
    logic       soft_req = 1'b0;
    logic       quiesce_ack = 1'b0;
    logic       quiesce_req;
    logic [2:0] rst_out_n;
    logic       ready;
    logic       timeout_flag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    h2f_reset_sequencer #(
        .NUM_STAGES     (3),
        .SYNC_STAGES    (2),
        .STAGE_DELAY    (4),
        .HOLD_CYCLES    (16),
        .QUIESCE_TIMEOUT(256)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h2f_rst_n   (h2f_rst_n),
        .soft_req    (soft_req),
        .quiesce_ack (quiesce_ack),
        .quiesce_req (quiesce_req),
        .rst_out_n   (rst_out_n),
        .ready       (ready),
        .timeout_flag(timeout_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stage vector k edges into a sequence whose stage 0 releases at edge 'first'.
    function automatic logic [2:0] exp_stages(input int k, input int first);
        if (k >= first + 8) return 3'b111;
        if (k >= first + 4) return 3'b011;
        if (k >= first)     return 3'b001;
        return 3'b000;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if (rst_out_n !== 3'b000) begin fails++; $display("FAIL reset_rst_out_n got %b want 000", rst_out_n); end
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
        tests++;
        if (quiesce_req !== 1'b0) begin fails++; $display("FAIL reset_quiesce_req got %b want 0", quiesce_req); end
        tests++;
        if (timeout_flag !== 1'b0) begin fails++; $display("FAIL reset_timeout_flag got %b want 0", timeout_flag); end
    endtask

    task automatic test_powerup();
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tests++;
            if (rst_out_n !== exp_stages(k, 6)) begin
                fails++; $display("FAIL powerup_stages k=%0d got %b want %b", k, rst_out_n, exp_stages(k, 6));
            end
            tests++;
            if (ready !== (k >= 14)) begin
                fails++; $display("FAIL powerup_ready k=%0d got %b want %b", k, ready, (k >= 14));
            end
        end
    endtask

    task automatic test_h2f_glitch();
        h2f_rst_n = 1'b0;
        #2;
        tests++;
        if (rst_out_n !== 3'b000) begin fails++; $display("FAIL glitch_async_stages got %b want 000", rst_out_n); end
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL glitch_async_ready got %b want 0", ready); end
        tick();
        h2f_rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tests++;
            if ({ready, rst_out_n} !== {(k >= 14), exp_stages(k, 6)}) begin
                fails++; $display("FAIL glitch_rerelease k=%0d got %b want %b", k, {ready, rst_out_n}, {(k >= 14), exp_stages(k, 6)});
            end
        end
    endtask

    task automatic test_soft_reset();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        tests++;
        if ({quiesce_req, ready, rst_out_n} !== 5'b10111) begin
            fails++; $display("FAIL soft_enter_quiesce got %b want 10111", {quiesce_req, ready, rst_out_n});
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            tests++;
            if ({quiesce_req, rst_out_n} !== 4'b1111) begin
                fails++; $display("FAIL soft_quiesce_hold k=%0d got %b want 1111", k, {quiesce_req, rst_out_n});
            end
        end
        quiesce_ack = 1'b1;
        for (int m = 0; m <= 30; m++) begin
            tick();
            if (m == 0) quiesce_ack = 1'b0;
            tests++;
            if ({quiesce_req, ready, rst_out_n} !== {1'b0, (m >= 28), exp_stages(m, 20)}) begin
                fails++; $display("FAIL soft_hold_release m=%0d got %b want %b", m, {quiesce_req, ready, rst_out_n}, {1'b0, (m >= 28), exp_stages(m, 20)});
            end
        end
    endtask

    task automatic test_soft_ignored();
        quiesce_ack = 1'b1;
        soft_req    = 1'b1;
        tick();
        soft_req = 1'b0;
        tests++;
        if (quiesce_req !== 1'b1) begin fails++; $display("FAIL early_ack_quiesce got %b want 1", quiesce_req); end
        tick();
        quiesce_ack = 1'b0;
        tests++;
        if ({quiesce_req, rst_out_n} !== 4'b0000) begin
            fails++; $display("FAIL early_ack_exit got %b want 0000", {quiesce_req, rst_out_n});
        end
        for (int m = 1; m <= 30; m++) begin
            soft_req = (m == 5) || (m == 22);
            tick();
            tests++;
            if ({quiesce_req, ready, rst_out_n} !== {1'b0, (m >= 28), exp_stages(m, 20)}) begin
                fails++; $display("FAIL ignore_in_hold m=%0d got %b want %b", m, {quiesce_req, ready, rst_out_n}, {1'b0, (m >= 28), exp_stages(m, 20)});
            end
        end
        soft_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            soft_req = (k == 8) || (k == 14);
            tick();
            tests++;
            if ({quiesce_req, ready, rst_out_n} !== {1'b0, (k >= 14), exp_stages(k, 6)}) begin
                fails++; $display("FAIL ignore_in_release k=%0d got %b want %b", k, {quiesce_req, ready, rst_out_n}, {1'b0, (k >= 14), exp_stages(k, 6)});
            end
        end
        soft_req = 1'b0;
    endtask

    task automatic test_quiesce_wait();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
        for (int k = 2; k <= 257; k++) begin
            if (k > 1) tick();
            tests++;
            if ({quiesce_req, rst_out_n, timeout_flag} !== ((k <= 256) ? 5'b11110 : 5'b00001)) begin
                fails++; $display("FAIL timeout_wait k=%0d got %b want %b", k, {quiesce_req, rst_out_n, timeout_flag}, ((k <= 256) ? 5'b11110 : 5'b00001));
            end
        end
        repeat (30) tick();
        tests++;
        if ({ready, timeout_flag} !== 2'b11) begin fails++; $display("FAIL timeout_recover got %b want 11", {ready, timeout_flag}); end
        quiesce_ack = 1'b1;
        soft_req    = 1'b1;
        tick();
        soft_req = 1'b0;
        tick();
        quiesce_ack = 1'b0;
        repeat (30) tick();
        tests++;
        if ({ready, timeout_flag} !== 2'b11) begin fails++; $display("FAIL timeout_sticky got %b want 11", {ready, timeout_flag}); end
`else
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) tick();
            tests++;
            if ({quiesce_req, ready, rst_out_n, timeout_flag} !== 6'b101110) begin
                fails++; $display("FAIL wait_forever k=%0d got %b want 101110", k, {quiesce_req, ready, rst_out_n, timeout_flag});
            end
        end
`endif
    endtask

    task automatic test_h2f_in_quiesce();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        tick();
        tests++;
        if (quiesce_req !== 1'b1) begin fails++; $display("FAIL h2f_q_pre got %b want 1", quiesce_req); end
        h2f_rst_n = 1'b0;
        #2;
        tests++;
        if ({quiesce_req, ready, rst_out_n, timeout_flag} !== 6'b000000) begin
            fails++; $display("FAIL h2f_q_async got %b want 000000", {quiesce_req, ready, rst_out_n, timeout_flag});
        end
        tick();
        h2f_rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tests++;
            if ({quiesce_req, ready, rst_out_n} !== {1'b0, (k >= 14), exp_stages(k, 6)}) begin
                fails++; $display("FAIL h2f_q_rerelease k=%0d got %b want %b", k, {quiesce_req, ready, rst_out_n}, {1'b0, (k >= 14), exp_stages(k, 6)});
            end
        end
        tests++;
        if (timeout_flag !== 1'b0) begin fails++; $display("FAIL h2f_q_flag got %b want 0", timeout_flag); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_h2f_glitch();
        test_soft_reset();
        test_soft_ignored();
        test_quiesce_wait();
        test_h2f_in_quiesce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
